// File: rtl/audio_delay.sv
// audio_delay: feedback echo stage placed after the ladder filter.
//
// Each accepted sample x is mixed with a delayed buffer word d:
//   sample_out = (x*(1024-m) + d*m) >>> 10          (dry/wet mix)
//   buffer[wp] = sat16(x + ((d*f) >>> 10))          (feedback write)
// The delay length comes from pot_time scaled to the buffer size. The buffer
// is a single-port, synchronous-read RAM. It is zero-filled after every reset
// (state CLEAR), so stale echoes can never leak out.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   pot_time          delay length pot (scaled by BUF_DEPTH/1024)
//   pot_feedback      feedback gain, pot/1024
//   pot_mix           wet fraction, pot/1024
//   sample_in         signed input sample, qualified by sample_in_valid
//   sample_out        signed mixed sample, qualified by sample_out_valid
//   busy              high in every state except IDLE
//
// Handshake: sample_in_valid and sample_out_valid are single-cycle strobes
// with no back-pressure. A strobe is consumed in IDLE (full echo path, result
// 4 cycles later) or in CLEAR (dry pass-through, result next cycle). A strobe
// in any other state is dropped.

module audio_delay #(
  parameter int BUF_DEPTH = 16384
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         pot_time,
  input  logic [9:0]         pot_feedback,
  input  logic [9:0]         pot_mix,
  input  logic signed [15:0] sample_in,
  input  logic               sample_in_valid,
  output logic signed [15:0] sample_out,
  output logic               sample_out_valid,
  output logic               busy
);

  localparam int AW = $clog2(BUF_DEPTH);

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    IDLE  = 3'd1,
    READ  = 3'd2,
    WAIT  = 3'd3,
    CALC  = 3'd4,
    WRITE = 3'd5
  } state_t;

  state_t state, state_next;

  logic [AW-1:0]      wp;
  logic [AW-1:0]      clear_addr;
  logic [AW-1:0]      ra;
  logic [AW-1:0]      delay_len;
  logic signed [15:0] x;
  logic signed [15:0] d;
  logic [9:0]         m;
  logic [9:0]         f;
  logic signed [27:0] fbp;

  // Buffer RAM and its single access port.
  logic [15:0]   mem [BUF_DEPTH];
  logic [15:0]   rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [15:0]   ram_wdata;

  // Arithmetic, all in signed 28-bit.
  logic signed [27:0] xe, de, me, ime, fe;
  logic signed [27:0] mixp, fbp_c, sum;
  logic signed [15:0] w;
  logic               unused_mix_bits;

  // Delay length: pot scaled up to the buffer size; zero would read the
  // word about to be written, so it is forced to one sample.
  always_comb begin
    delay_len = AW'(pot_time) << (AW - 10);
    if (delay_len == '0) delay_len = AW'(1);
  end

  always_comb begin
    xe    = {{12{x[15]}}, x};
    de    = {{12{d[15]}}, d};
    me    = {18'd0, m};
    fe    = {18'd0, f};
    ime   = 28'sd1024 - me;
    mixp  = xe * ime + de * me;
    fbp_c = de * fe;
    sum   = xe + (fbp >>> 10);
    if (sum > 28'sd32767)       w = 16'sh7fff;
    else if (sum < -28'sd32768) w = 16'sh8000;
    else                        w = sum[15:0];
  end

  // The mix is a convex combination, so bits 25:10 carry the full result.
  assign unused_mix_bits = ^{mixp[27:26], mixp[9:0]};

  assign busy = (state != IDLE);

  // Next state and RAM port steering.
  always_comb begin
    state_next = state;
    ram_addr   = wp;
    ram_we     = 1'b0;
    ram_wdata  = 16'd0;
    case (state)
      CLEAR: begin
        ram_addr = clear_addr;
        ram_we   = 1'b1;
        if (&clear_addr) state_next = IDLE;
      end
      IDLE:  if (sample_in_valid) state_next = READ;
      READ: begin
        ram_addr   = ra;
        state_next = WAIT;
      end
      WAIT:  state_next = CALC;
      CALC:  state_next = WRITE;
      WRITE: begin
        ram_addr   = wp;
        ram_we     = 1'b1;
        ram_wdata  = w;
        state_next = IDLE;
      end
      default: state_next = CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= CLEAR;
      wp               <= '0;
      clear_addr       <= '0;
      ra               <= '0;
      x                <= '0;
      d                <= '0;
      m                <= '0;
      f                <= '0;
      fbp              <= '0;
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
    end else begin
      state            <= state_next;
      sample_out_valid <= 1'b0;
      case (state)
        CLEAR: begin
          clear_addr <= clear_addr + 1'b1;
          if (sample_in_valid) begin
            sample_out       <= sample_in;
            sample_out_valid <= 1'b1;
          end
        end
        IDLE: begin
          if (sample_in_valid) begin
            x  <= sample_in;
            m  <= pot_mix;
            f  <= pot_feedback;
            ra <= wp - delay_len;
          end
        end
        WAIT: d <= rdata;
        CALC: begin
          // Output is registered here so it is presented during WRITE.
          fbp              <= fbp_c;
          sample_out       <= mixp[25:10];
          sample_out_valid <= 1'b1;
        end
        WRITE: wp <= wp + 1'b1;
        default: ;
      endcase
    end
  end

  // Buffer RAM: contents are never reset; CLEAR zero-fills them instead.
  always_ff @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    rdata <= mem[ram_addr];
  end

endmodule

// File: tb/tb_audio_delay.sv
// Self-checking bench for audio_delay with BUF_DEPTH=1024.
// The reference model keeps the history of buffer writes since the last
// clear in a queue; the delayed word is the entry D writes back.
module tb_audio_delay;

  localparam int DEPTH = 1024;
  localparam int AW    = 10;

  logic               clk;
  logic               rst;
  logic [9:0]         pot_time;
  logic [9:0]         pot_feedback;
  logic [9:0]         pot_mix;
  logic signed [15:0] sample_in;
  logic               sample_in_valid;
  logic signed [15:0] sample_out;
  logic               sample_out_valid;
  logic               busy;

  int n_checks;
  int n_fail;
  int hist[$];

  audio_delay #(.BUF_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .pot_time         (pot_time),
    .pot_feedback     (pot_feedback),
    .pot_mix          (pot_mix),
    .sample_in        (sample_in),
    .sample_in_valid  (sample_in_valid),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .busy             (busy)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got no end, want end");
    $fatal(1, "watchdog");
  end

  // Reference model: one accepted sample.
  task automatic model_step(input int x, input int t, input int f, input int m, output int out);
    int dl, dv, wv;
    dl = t * (DEPTH / 1024);
    if (dl == 0) dl = 1;
    dv = (dl <= hist.size()) ? hist[hist.size() - dl] : 0;
    out = (x * (1024 - m) + dv * m) >>> 10;
    wv = x + ((dv * f) >>> 10);
    if (wv > 32767) wv = 32767;
    if (wv < -32768) wv = -32768;
    hist.push_back(wv);
  endtask

  // Driver: sends one sample and checks latency and value against the model.
  // Pots and sample_in are scrambled right after acceptance.
  task automatic send(input int x, input int t, input int f, input int m,
                      input bit extra, output int got);
    int exp_v;
    logic signed [15:0] e16;
    model_step(x, t, f, m, exp_v);
    e16 = exp_v[15:0];
    sample_in       = x[15:0];
    pot_time        = t[9:0];
    pot_feedback    = f[9:0];
    pot_mix         = m[9:0];
    sample_in_valid = 1'b1;
    @(posedge clk); #1;
    sample_in_valid = 1'b0;
    pot_time        = 10'($urandom_range(0, 1023));
    pot_feedback    = 10'($urandom_range(0, 1023));
    pot_mix         = 10'($urandom_range(0, 1023));
    sample_in       = 16'($urandom_range(0, 65535));
    for (int k = 1; k <= 3; k++) begin
      n_checks++;
      if (sample_out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL early_valid: cycle %0d valid=%b, want 0", k, sample_out_valid);
      end
      if (extra && k == 2) sample_in_valid = 1'b1;
      @(posedge clk); #1;
      sample_in_valid = 1'b0;
    end
    n_checks++;
    if (sample_out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL latency: cycle 4 valid=%b, want 1", sample_out_valid);
    end
    n_checks++;
    if (sample_out !== e16) begin
      n_fail++;
      $display("FAIL sample_value: x=%0d t=%0d f=%0d m=%0d got %0d, want %0d",
               x, t, f, m, sample_out, e16);
    end
    got = int'(sample_out);
    @(posedge clk); #1;
    if (extra) begin
      for (int k = 5; k <= 8; k++) begin
        n_checks++;
        if (sample_out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL dropped_strobe: cycle %0d valid=%b, want 0", k, sample_out_valid);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  // Counts cycles of CLEAR after rst is released; optionally tests the dry path.
  task automatic wait_clear(input bit strobe);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      if (strobe && n == 100) begin
        sample_in       = 16'sd1234;
        sample_in_valid = 1'b1;
      end
      @(posedge clk); #1;
      sample_in_valid = 1'b0;
      n++;
      if (strobe && n == 101) begin
        n_checks++;
        if (sample_out_valid !== 1'b1 || sample_out !== 16'sd1234) begin
          n_fail++;
          $display("FAIL clear_passthrough: valid=%b out=%0d, want 1 / 1234",
                   sample_out_valid, sample_out);
        end
      end
      if (!strobe && n <= 5) begin
        n_checks++;
        if (sample_out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL clear_no_valid: cycle %0d valid=%b, want 0", n, sample_out_valid);
        end
      end
    end
    n_checks++;
    if (n != DEPTH) begin
      n_fail++;
      $display("FAIL clear_length: busy for %0d cycles, want %0d", n, DEPTH);
    end
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    sample_in_valid = 1'b0;
    sample_in       = 16'($urandom_range(0, 65535));
    pot_time        = 10'd0;
    pot_feedback    = 10'd0;
    pot_mix         = 10'd0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (sample_out !== 16'sd0 || sample_out_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_values: out=%0d valid=%b busy=%b, want 0/0/1",
               sample_out, sample_out_valid, busy);
    end
    rst = 1'b0;
    hist.delete();
    wait_clear(1'b1);
  endtask

  task automatic test_impulse_echo();
    int exp_t[11] = '{512, 0, 0, 0, 0, 512, 0, 0, 0, 0, 0};
    int got;
    for (int i = 0; i < 11; i++) begin
      send((i == 0) ? 1024 : 0, 5, 0, 512, 1'b0, got);
      n_checks++;
      if (got != exp_t[i]) begin
        n_fail++;
        $display("FAIL impulse_echo: sample %0d got %0d, want %0d", i, got, exp_t[i]);
      end
    end
  endtask

  task automatic test_feedback_decay();
    int exp_t[12] = '{8192, 0, 0, 8192, 0, 0, 4096, 0, 0, 2048, 0, 0};
    int got;
    for (int i = 0; i < 12; i++) begin
      send((i == 0) ? 16384 : 0, 3, 512, 512, 1'b0, got);
      n_checks++;
      if (got != exp_t[i]) begin
        n_fail++;
        $display("FAIL feedback_decay: sample %0d got %0d, want %0d", i, got, exp_t[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int got;
    send(30000, 1, 1023, 0, 1'b0, got);
    send(30000, 1, 1023, 0, 1'b0, got);
    send(0, 1, 0, 1023, 1'b0, got);
    n_checks++;
    if (got != 32735) begin
      n_fail++;
      $display("FAIL saturation: got %0d, want 32735", got);
    end
  endtask

  task automatic test_random();
    int got, x, t;
    for (int i = 0; i < 150; i++) begin
      x = int'($urandom_range(0, 65535)) - 32768;
      case ($urandom_range(0, 3))
        0:       t = 0;
        1:       t = int'($urandom_range(0, 1023));
        default: t = int'($urandom_range(1, 12));
      endcase
      send(x, t, int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)), 1'b0, got);
    end
  endtask

  task automatic test_wrap();
    int got, want;
    for (int i = 0; i < 2000; i++) begin
      send(i, 1023, 0, 1023, (i == 1500), got);
      if (i >= 1023) begin
        want = (i + (i - 1023) * 1023) >>> 10;
        n_checks++;
        if (got != want) begin
          n_fail++;
          $display("FAIL wrap: sample %0d got %0d, want %0d", i, got, want);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int got;
    sample_in       = 16'sd7000;
    pot_time        = 10'd1;
    pot_feedback    = 10'd512;
    pot_mix         = 10'd1023;
    sample_in_valid = 1'b1;
    @(posedge clk); #1;
    sample_in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (sample_out_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b busy=%b, want 0/1", sample_out_valid, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    hist.delete();
    wait_clear(1'b0);
    send(0, 5, int'($urandom_range(0, 1023)), 1023, 1'b0, got);
    n_checks++;
    if (got != 0) begin
      n_fail++;
      $display("FAIL reclear_zero: got %0d, want 0", got);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_impulse_echo();
    test_feedback_decay();
    test_saturation();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_delay.md
Name: audio_delay

Overview:
- Feedback echo stage that sits directly downstream of the 4-pole ladder filter.
- Consumes the filter's sample_out/sample_out_valid stream and produces a dry/wet mixed echo stream for the output mixer.
- Stores delayed samples in a circular buffer (inferred block RAM), with delay time, feedback gain and wet mix set by 10-bit pots.

Parameters:
- BUF_DEPTH, 16384, buffer length in samples; power of two, >= 1024; AW = log2(BUF_DEPTH).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- pot_time  input  10  delay-length pot
- pot_feedback  input  10  feedback gain, pot/1024
- pot_mix  input  10  wet fraction, pot/1024
- sample_in  input  16  signed sample from the filter
- sample_in_valid  input  1  one-cycle strobe
- sample_out  output  16  signed mixed sample
- sample_out_valid  output  1  one-cycle strobe
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset values:
  - sample_out=0, sample_out_valid=0, busy=1.
  - Write pointer wp=0, clear address=0, state=CLEAR.
- Buffer RAM: single port, synchronous read, 1-cycle read latency, one access per cycle. Contents are not reset.
- State CLEAR:
  - Writes 0 to address clear_addr each cycle, incrementing it.
  - After address BUF_DEPTH-1 is written, go to IDLE (BUF_DEPTH cycles after rst deasserts).
  - A sample_in_valid during CLEAR is passed dry: the next cycle gives sample_out=sample_in and sample_out_valid=1. It is not written to the buffer.
- State IDLE:
  - On sample_in_valid, latch x=sample_in, m=pot_mix, f=pot_feedback.
  - Compute D = pot_time << (AW-10); if D==0 then D=1.
  - Read address ra = (wp - D) mod BUF_DEPTH, with AW-bit wrap-around.
  - Go to READ.
- State READ: drive ra to the RAM; go to WAIT.
- State WAIT: capture d = RAM data (signed 16); go to CALC.
- State CALC (all products signed 28-bit):
  - fbp = d*f.
  - mixp = x*(1024-m) + d*m.
  - Go to WRITE.
- State WRITE:
  - Write word w = sat16(x + (fbp>>>10)) at wp, clamped to [-32768, 32767].
  - sample_out = mixp>>>10; no saturation needed because the mix is a convex combination.
  - sample_out_valid=1 for exactly this one cycle.
  - wp = wp+1, wrapping at BUF_DEPTH.
  - Go to IDLE.
- Latency: sample_out_valid rises exactly 4 cycles after the accepting sample_in_valid cycle.
- All right shifts are arithmetic (floor). No rounding.
- sample_in_valid while busy and not in CLEAR is ignored (dropped). The upstream sample rate guarantees at least 5 cycles between strobes.
- Pots are sampled only at acceptance. Pot changes mid-sample have no effect until the next sample.
- D larger than the samples written since reset reads cleared zeros.
- Reset mid-operation:
  - Any in-flight sample is discarded; no sample_out_valid.
  - Restart in CLEAR at address 0 with wp=0.
  - Prior buffer contents must not appear in the output.

Test Plan:
- Reset, BUF_DEPTH=1024: busy=1 for 1024 cycles then 0. A strobe with sample_in=1234 during CLEAR gives sample_out=1234 with valid on the next cycle.
- After clear, pot_time=5, pot_feedback=0, pot_mix=512, impulse 1024 then zeros:
  - Sample 0 output = 512.
  - Samples 1-4 output = 0.
  - Sample 5 output = 512.
  - Sample 10 output = 0.
  - Each output valid exactly 4 cycles after its input.
- pot_time=3, pot_feedback=512, pot_mix=512, impulse 16384 then zeros: outputs at samples 0, 3, 6, 9 = 8192, 8192, 4096, 2048; all others 0.
- Saturation: pot_time=1, pot_feedback=1023, inputs 30000 then 30000 (the second sample writes sat(30000+29970)=32767). Then pot_feedback=0, pot_mix=1023, input 0: output = 32735.
- Wrap-around: pot_time=1023, 2000 consecutive samples with value = index. Output wet part equals sample index-1023 across the wp wrap at 1024. A strobe 2 cycles after another is ignored (no extra valid).
- Assert rst during CALC: no sample_out_valid, busy=1. After re-clear, a 0-input sample with pot_mix=1023 returns 0.
